// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of the single-port data memory / MMIO bus.
//   Port A is the CPU load/store path, port B a secondary master (loader or
//   debug). The block decides which request is issued each cycle, routes the
//   one-cycle-late read data back to the port that issued the read, and keeps
//   B from starving behind A.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> unlocked contention alternates strictly between A and B
//     undefined -> fixed A priority with a MAX_WAIT starvation override for B
//
// Ports
//   clk, reset                   single clock, synchronous active-high reset
//   a_req/a_we/a_lock            A request, write select, burst hold
//   a_addr/a_wdata               A address and write data
//   a_gnt                        A issued to memory this cycle
//   a_rvalid/a_rdata             A read return (rdata is 0 when not valid)
//   b_*                          same set for port B
//   mem_en/mem_we                memory strobe and write enable
//   mem_addr/mem_wdata           muxed address / write data (0 when idle)
//   mem_rdata                    memory read data, one cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int MAX_WAIT  = 8,
  parameter int CNT_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] b_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2
  } port_e;

  port_e owner_r;
  port_e rd_pend_r;
  port_e grant_s;

`ifdef ARB_ROUND_ROBIN_EN
  // Only alternation needs to remember who went last.
  port_e last_r;
`else
  localparam logic [CNT_BITS-1:0] WAIT_LIM = CNT_BITS'(MAX_WAIT);
  localparam logic [CNT_BITS-1:0] WAIT_SAT = {CNT_BITS{1'b1}};
  logic [CNT_BITS-1:0] wait_r;
`endif

  // Grant decision: lock hold first, then contention policy, then lone requester.
  always_comb begin
    grant_s = PORT_NONE;
    if (reset) begin
      grant_s = PORT_NONE;
    end else if ((owner_r == PORT_A) && a_req) begin
      grant_s = PORT_A;
    end else if ((owner_r == PORT_B) && b_req) begin
      grant_s = PORT_B;
    end else if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_s = (last_r == PORT_A) ? PORT_B : PORT_A;
`else
      grant_s = (wait_r >= WAIT_LIM) ? PORT_B : PORT_A;
`endif
    end else if (a_req) begin
      grant_s = PORT_A;
    end else if (b_req) begin
      grant_s = PORT_B;
    end else begin
      grant_s = PORT_NONE;
    end
  end

  // Memory-side mux and grant strobes; everything idles to zero.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant_s)
      PORT_A: begin
        a_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = a_we;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
      end
      PORT_B: begin
        b_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = b_we;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Read return routing; reset masks any read still in flight.
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = '0;
    b_rdata  = '0;
    if (!reset) begin
      a_rvalid = (rd_pend_r == PORT_A);
      b_rvalid = (rd_pend_r == PORT_B);
      a_rdata  = a_rvalid ? mem_rdata : '0;
      b_rdata  = b_rvalid ? mem_rdata : '0;
    end else begin
      a_rvalid = 1'b0;
      b_rvalid = 1'b0;
    end
  end

  // Ownership, pending-read tag and fairness state.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r   <= PORT_NONE;
      rd_pend_r <= PORT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
      last_r    <= PORT_B;
`else
      wait_r    <= '0;
`endif
    end else begin
      if ((grant_s == PORT_A) && a_lock) begin
        owner_r <= PORT_A;
      end else if ((grant_s == PORT_B) && b_lock) begin
        owner_r <= PORT_B;
      end else begin
        owner_r <= PORT_NONE;
      end

      if ((grant_s == PORT_A) && !a_we) begin
        rd_pend_r <= PORT_A;
      end else if ((grant_s == PORT_B) && !b_we) begin
        rd_pend_r <= PORT_B;
      end else begin
        rd_pend_r <= PORT_NONE;
      end

`ifdef ARB_ROUND_ROBIN_EN
      if (grant_s != PORT_NONE) begin
        last_r <= grant_s;
      end else begin
        last_r <= last_r;
      end
`else
      // B's refusal count saturates so priority sticks until B is served.
      if (!b_req || (grant_s == PORT_B)) begin
        wait_r <= '0;
      end else if (wait_r != WAIT_SAT) begin
        wait_r <= wait_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end else begin
        wait_r <= wait_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a read-return scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;

  int checks   = 0;
  int failures = 0;
  int cur_row  = 0;

  typedef struct {
    logic        rst;
    logic        areq, awe, alock;
    logic [31:0] aaddr;
    logic        breq, bwe, block;
    logic [31:0] baddr;
    logic        ea, eb, erva, ervb;
  } vec_t;

  typedef struct {
    logic        port_b;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  dmem_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .MAX_WAIT(8), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory model: answers reads one cycle later, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, cur_row, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic areq, input logic awe, input logic alock,
                     input logic [31:0] aaddr, input logic breq, input logic bwe,
                     input logic block, input logic [31:0] baddr, input logic ea,
                     input logic eb, input logic erva, input logic ervb);
    vec_t v;
    v.rst = rst; v.areq = areq; v.awe = awe; v.alock = alock; v.aaddr = aaddr;
    v.breq = breq; v.bwe = bwe; v.block = block; v.baddr = baddr;
    v.ea = ea; v.eb = eb; v.erva = erva; v.ervb = ervb;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic erva, input logic ervb);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, erva, ervb);
  endtask

  initial begin
    vec_t        v;
    sb_t         e;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;

    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;

    // Reset: requests present but nothing may be granted.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    // Continuous contention alternates, A first after reset.
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(k * 4), 1'b1, 1'b0, 1'b0, 32'h200 + 32'(k * 4),
          (k % 2) == 0, (k % 2) == 1, k == 1 || k == 3, k == 2);
    idle(1'b0, 1'b1);
`else
    // Contention: A wins 8 times, B forced on the 9th, then A again.
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(k * 4), 1'b1, 1'b0, 1'b0, 32'h200,
          k != 8, k == 8, k >= 1 && k <= 8, k == 9);
    idle(1'b1, 1'b0);
`endif
    // Lone A read, lone A write, lone B read.
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    // B locked write burst holds off A until the lock is released.
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b1, 1'b1, 32'h64, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b1, 1'b0, 32'h68, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b1, 1'b0, 32'h6C, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    // Back-to-back alternating reads.
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h70, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h74, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h78, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h7C, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    // Locked owner drops req: B wins in that same cycle.
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h88, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    // Reset right after a locked B read: return suppressed, ownership gone.
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h90, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 32'hA4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cur_row = i;
      @(negedge clk);
      reset  = v.rst;
      a_req  = v.areq; a_we = v.awe; a_lock = v.alock; a_addr = v.aaddr;
      a_wdata = v.aaddr ^ 32'h1111_1111;
      b_req  = v.breq; b_we = v.bwe; b_lock = v.block; b_addr = v.baddr;
      b_wdata = v.baddr ^ 32'h2222_2222;
      #1;
      exp_we    = v.ea ? v.awe : (v.eb ? v.bwe : 1'b0);
      exp_addr  = v.ea ? v.aaddr : (v.eb ? v.baddr : 32'h0);
      exp_wdata = v.ea ? (v.aaddr ^ 32'h1111_1111) : (v.eb ? (v.baddr ^ 32'h2222_2222) : 32'h0);
      chk("a_gnt",     32'(a_gnt),    32'(v.ea));
      chk("b_gnt",     32'(b_gnt),    32'(v.eb));
      chk("mem_en",    32'(mem_en),   32'(v.ea | v.eb));
      chk("mem_we",    32'(mem_we),   32'(exp_we));
      chk("mem_addr",  mem_addr,      exp_addr);
      chk("mem_wdata", mem_wdata,     exp_wdata);
      chk("a_rvalid",  32'(a_rvalid), 32'(v.erva));
      chk("b_rvalid",  32'(b_rvalid), 32'(v.ervb));
      if (v.erva || v.ervb) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rd_port", 32'(v.ervb), 32'(e.port_b));
          chk(v.ervb ? "b_rdata" : "a_rdata", v.ervb ? b_rdata : a_rdata, e.data);
        end
      end
      if (!v.erva) chk("a_rdata_idle", a_rdata, 32'h0);
      if (!v.ervb) chk("b_rdata_idle", b_rdata, 32'h0);
      if (v.rst) sb.delete();
      if (v.ea && !v.awe) begin
        e.port_b = 1'b0; e.data = mem_val(v.aaddr); sb.push_back(e);
      end else if (v.eb && !v.bwe) begin
        e.port_b = 1'b1; e.data = mem_val(v.baddr); sb.push_back(e);
      end
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
